// File: rtl/mem_interconnect_wrr.sv
// mem_interconnect_wrr
//   N-core to one-memory interconnect. Each core owns a request FIFO; a
//   weighted round-robin arbiter picks which FIFO feeds a single registered
//   memory request port. Per-core credit counters bound the number of
//   issued-but-unanswered requests. Memory responses are routed back to the
//   core named by mem_rsp.core_id.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   core_req[i]       core request, .vld qualifies
//   core_req_rdy[i]   FIFO i has room (derived from registered occupancy)
//   core_rsp[i]       registered response, one-cycle .vld pulse
//   weight_cfg[i]     consecutive-issue budget for core i (0 acts as 1)
//   mem_req           registered memory request, .vld qualifies
//   mem_req_rdy       memory accepts mem_req
//   mem_rsp           memory response, .core_id picks the destination
//   rsp_err           one-cycle pulse when a response is dropped
//   dbg_arb_state     arbiter state (0 idle, 1 grant held)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a valid source keeps its payload stable until that edge and
// ready never depends combinationally on valid.

package mem_interconnect_wrr_pkg;
    typedef struct packed {
        logic        vld;
        logic [3:0]  core_id;
        logic        we;
        logic [7:0]  access_length;
        logic [15:0] addr;
        logic [15:0] data;
    } request_t;
endpackage

module mem_interconnect_wrr
    import mem_interconnect_wrr_pkg::*;
#(
    parameter int NUM_CORES       = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int WEIGHT_W        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  request_t             core_req     [NUM_CORES],
    output logic [NUM_CORES-1:0] core_req_rdy,
    output request_t             core_rsp     [NUM_CORES],
    input  logic [WEIGHT_W-1:0]  weight_cfg   [NUM_CORES],
    output request_t             mem_req,
    input  logic                 mem_req_rdy,
    input  request_t             mem_rsp,
    output logic                 rsp_err,
    output logic [0:0]           dbg_arb_state
);
    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_CORES - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] add_mod(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_CORES) s = s - NUM_CORES;
        return IDX_W'(s);
    endfunction

    // State
    request_t             fifo_mem_q [NUM_CORES][FIFO_DEPTH];
    request_t             fifo_mem_d [NUM_CORES][FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q [NUM_CORES], wr_ptr_d [NUM_CORES];
    logic [PTR_W-1:0]     rd_ptr_q [NUM_CORES], rd_ptr_d [NUM_CORES];
    logic [CNT_W-1:0]     count_q  [NUM_CORES], count_d  [NUM_CORES];
    logic [OUT_W-1:0]     outst_q  [NUM_CORES], outst_d  [NUM_CORES];
    request_t             core_rsp_q [NUM_CORES], core_rsp_d [NUM_CORES];
    request_t             mem_req_q, mem_req_d;
    logic [IDX_W-1:0]     src_q, src_d;
    logic [0:0]           state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [WEIGHT_W-1:0]  budget_q, budget_d;
    logic                 rsp_err_q, rsp_err_d;

    // Combinational helpers
    logic [NUM_CORES-1:0] eligible;
    logic [OUT_W:0]       eff_out [NUM_CORES];
    logic                 can_load;
    logic                 hs;
    logic [IDX_W-1:0]     sp;
    logic                 found;
    logic [IDX_W-1:0]     win;
    logic [WEIGHT_W-1:0]  w_eff;
    logic                 start_grant;
    logic                 issue;
    logic [IDX_W-1:0]     issue_idx;
    logic [NUM_CORES-1:0] push;
    logic [NUM_CORES-1:0] pop;
    logic [NUM_CORES-1:0] inc;
    logic [NUM_CORES-1:0] rsp_hit;

    // A request parked in the output register already consumes a credit;
    // counting it here keeps the limit exact while memory is ready.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            core_req_rdy[i] = (count_q[i] != CNT_W'(FIFO_DEPTH));
            eff_out[i] = {1'b0, outst_q[i]}
                       + {{OUT_W{1'b0}}, (mem_req_q.vld && (src_q == IDX_W'(i)))};
            eligible[i] = (count_q[i] != '0) && (eff_out[i] < (OUT_W+1)'(MAX_OUTSTANDING));
        end
    end

    // Weighted round-robin arbiter. A grant that ends on budget exhaustion
    // goes through IDLE, which grants and issues in the same cycle, so the
    // next core still issues without a bubble. A grant that ends on
    // ineligibility re-arbitrates from granted+1 immediately.
    always_comb begin
        can_load = !mem_req_q.vld || mem_req_rdy;
        hs       = mem_req_q.vld && mem_req_rdy;
        sp       = (state_q == ST_GRANT) ? next_idx(grant_q) : rr_ptr_q;

        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!found && eligible[add_mod(sp, k)]) begin
                found = 1'b1;
                win   = add_mod(sp, k);
            end
        end
        w_eff = (weight_cfg[win] == '0) ? WEIGHT_W'(1) : weight_cfg[win];

        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        budget_d    = budget_q;
        start_grant = 1'b0;
        issue       = 1'b0;
        issue_idx   = grant_q;

        if (state_q == ST_GRANT) begin
            if (eligible[grant_q]) begin
                if (can_load) begin
                    issue = 1'b1;
                    if (budget_q <= WEIGHT_W'(1)) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = next_idx(grant_q);
                        budget_d = '0;
                    end else begin
                        budget_d = budget_q - WEIGHT_W'(1);
                    end
                end
            end else if (can_load) begin
                rr_ptr_d = sp;
                if (found) begin
                    start_grant = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    budget_d = '0;
                end
            end
        end else if (found) begin
            start_grant = 1'b1;
        end

        if (start_grant) begin
            grant_d  = win;
            state_d  = ST_GRANT;
            budget_d = w_eff;
            if (can_load) begin
                issue     = 1'b1;
                issue_idx = win;
                if (w_eff == WEIGHT_W'(1)) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_idx(win);
                    budget_d = '0;
                end else begin
                    budget_d = w_eff - WEIGHT_W'(1);
                end
            end
        end
    end

    // FIFOs and the output register
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_req_d  = mem_req_q;
        src_d      = src_q;
        push       = '0;
        pop        = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            push[i] = core_req[i].vld && core_req_rdy[i];
            pop[i]  = issue && (issue_idx == IDX_W'(i));
            if (push[i]) begin
                fifo_mem_d[i][wr_ptr_q[i]] = core_req[i];
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
        if (issue) begin
            mem_req_d = fifo_mem_q[issue_idx][rd_ptr_q[issue_idx]];
            src_d     = issue_idx;
        end else if (hs) begin
            mem_req_d = '0;
        end
    end

    // Credits and response routing. Out-of-range core_id never matches
    // any rsp_hit bit, so it falls through to rsp_err.
    always_comb begin
        outst_d = outst_q;
        inc     = '0;
        rsp_hit = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            rsp_hit[i] = mem_rsp.vld && (5'(mem_rsp.core_id) == 5'(i)) && (outst_q[i] != '0);
            inc[i]     = hs && (src_q == IDX_W'(i));
            if (inc[i] && !rsp_hit[i]) begin
                if (outst_q[i] != OUT_W'(MAX_OUTSTANDING)) outst_d[i] = outst_q[i] + OUT_W'(1);
            end else if (rsp_hit[i] && !inc[i]) begin
                outst_d[i] = outst_q[i] - OUT_W'(1);
            end
            core_rsp_d[i] = rsp_hit[i] ? mem_rsp : '0;
        end
        rsp_err_d = mem_rsp.vld && (rsp_hit == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                wr_ptr_q[i]   <= '0;
                rd_ptr_q[i]   <= '0;
                count_q[i]    <= '0;
                outst_q[i]    <= '0;
                core_rsp_q[i] <= '0;
            end
            mem_req_q <= '0;
            src_q     <= '0;
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            budget_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            core_rsp_q <= core_rsp_d;
            mem_req_q  <= mem_req_d;
            src_q      <= src_d;
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            budget_q   <= budget_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Storage needs no reset: pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    assign core_rsp      = core_rsp_q;
    assign mem_req       = mem_req_q;
    assign rsp_err       = rsp_err_q;
    assign dbg_arb_state = state_q;

endmodule

// File: tb/tb_mem_interconnect_wrr.sv
// Bench for mem_interconnect_wrr (NUM_CORES=4, FIFO_DEPTH=4, MAX_OUTSTANDING=8).
module tb_mem_interconnect_wrr;
    import mem_interconnect_wrr_pkg::*;

    localparam int RW = $bits(request_t);

    // Clock / reset
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    request_t   core_req   [4];
    logic [3:0] core_req_rdy;
    request_t   core_rsp   [4];
    logic [3:0] weight_cfg [4];
    request_t   mem_req;
    logic       mem_req_rdy;
    request_t   mem_rsp;
    logic       rsp_err;
    logic [0:0] dbg_state;

    mem_interconnect_wrr #(
        .NUM_CORES(4), .FIFO_DEPTH(4), .MAX_OUTSTANDING(8), .WEIGHT_W(4)
    ) dut (
        .clk(clk), .reset(rst_n),
        .core_req(core_req), .core_req_rdy(core_req_rdy),
        .core_rsp(core_rsp), .weight_cfg(weight_cfg),
        .mem_req(mem_req), .mem_req_rdy(mem_req_rdy),
        .mem_rsp(mem_rsp), .rsp_err(rsp_err),
        .dbg_arb_state(dbg_state)
    );

    // Scoreboard and bookkeeping
    logic [RW-1:0] exp_q [$];
    int  log_core [$];
    int  log_cyc  [$];
    int  hs_cnt   [4];
    int  remaining[4];
    int  seq      [4];
    int  cyc;
    bit  auto_rsp;
    bit  sb_en;
    int  n_checks;
    int  n_fail;

    typedef struct packed {
        logic [15:0] w;      // core 0 in the top nibble
        logic [47:0] order;  // expected issuing core, first issue in the top nibble
    } order_vec_t;
    order_vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic request_t make_req(input int core, input int s);
        request_t r;
        r = '0;
        r.vld           = 1'b1;
        r.core_id       = 4'(core);
        r.we            = s[0];
        r.access_length = 8'd5;
        r.addr          = 16'(s);
        r.data          = 16'(core * 256 + s);
        return r;
    endfunction

    function automatic logic any_rsp();
        logic a;
        a = 1'b0;
        for (int i = 0; i < 4; i++) a = a | (core_rsp[i] != '0);
        return a;
    endfunction

    task automatic refresh_drive();
        for (int i = 0; i < 4; i++)
            core_req[i] = (remaining[i] > 0) ? make_req(i, seq[i]) : '0;
    endtask

    // Driver: one clock per call. Transfers are judged from values just
    // before the edge, outputs are sampled 1 time unit after it.
    task automatic tick();
        logic [3:0] acc;
        logic       hs;
        request_t   hs_req;
        for (int i = 0; i < 4; i++) acc[i] = core_req[i].vld && core_req_rdy[i];
        hs     = mem_req.vld && mem_req_rdy;
        hs_req = mem_req;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                if (sb_en) exp_q.push_back(core_req[i]);
                seq[i]++;
                remaining[i]--;
            end
        end
        if (hs) begin
            log_core.push_back(int'(hs_req.core_id));
            log_cyc.push_back(cyc);
            if (int'(hs_req.core_id) < 4) hs_cnt[int'(hs_req.core_id)]++;
            if (sb_en) begin
                if (exp_q.size() == 0) check("sb_unexpected_issue", hs_req, '0);
                else check("sb_order", hs_req, exp_q.pop_front());
            end
        end
        mem_rsp = (auto_rsp && hs) ? hs_req : '0;
        refresh_drive();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        mem_req_rdy = 1'b0;
        mem_rsp     = '0;
        auto_rsp    = 1'b0;
        sb_en       = 1'b0;
        exp_q.delete();
        log_core.delete();
        log_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            remaining[i]  = 0;
            seq[i]        = 0;
            hs_cnt[i]     = 0;
            weight_cfg[i] = 4'd1;
        end
        refresh_drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        request_t r;
        int got;
        int exp_c;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;

        vecs[0].w = 16'h1111; vecs[0].order = 48'h0123_0123_0123;
        vecs[1].w = 16'h3121; vecs[1].order = 48'h0001_2230_0012;
        vecs[2].w = 16'h3021; vecs[2].order = 48'h0001_2230_0012;
        vecs[3].w = 16'h2210; vecs[3].order = 48'h0011_2300_1123;

        // Reset state
        do_reset();
        check("rst_mem_req", mem_req, '0);
        check("rst_rdy", core_req_rdy, 4'hF);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_core_rsp", any_rsp(), 1'b0);
        check("rst_state", dbg_state, 1'b0);

        // Table-driven arbitration order, memory always ready
        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int i = 0; i < 4; i++) weight_cfg[i] = vecs[v].w[15-4*i -: 4];
            mem_req_rdy = 1'b1;
            auto_rsp    = 1'b1;
            for (int i = 0; i < 4; i++) remaining[i] = 1000;
            refresh_drive();
            for (int c = 0; c < 40 && log_core.size() < 12; c++) tick();
            for (int k = 0; k < 12; k++) begin
                exp_c = int'(vecs[v].order[47-4*k -: 4]);
                got   = (k < log_core.size()) ? log_core[k] : -1;
                check($sformatf("order_v%0d_k%0d", v, k), got, exp_c);
                if (k > 0) begin
                    got = (k < log_cyc.size()) ? (log_cyc[k] - log_cyc[k-1]) : -1;
                    check($sformatf("gap_v%0d_k%0d", v, k), got, 1);
                end
            end
        end

        // Single-core latency and response routing
        do_reset();
        mem_req_rdy  = 1'b1;
        remaining[2] = 1;
        refresh_drive();
        tick();
        check("lat_accepted", seq[2], 1);
        check("lat_not_yet", mem_req.vld, 1'b0);
        tick();
        check("lat_mem_req", mem_req, make_req(2, 0));
        tick();
        check("lat_reg_cleared", mem_req.vld, 1'b0);
        r = make_req(2, 0);
        r.data = 16'hBEEF;
        mem_rsp = r;
        tick();
        check("rsp_core2", core_rsp[2], r);
        check("rsp_core0", core_rsp[0], '0);
        check("rsp_core1", core_rsp[1], '0);
        check("rsp_core3", core_rsp[3], '0);
        check("rsp_no_err", rsp_err, 1'b0);
        tick();
        check("rsp_pulse_end", core_rsp[2], '0);

        // Response errors: zero outstanding, then out-of-range core_id
        mem_rsp = r;
        tick();
        check("err_zero_outst", rsp_err, 1'b1);
        check("err_zero_no_rsp", any_rsp(), 1'b0);
        tick();
        check("err_pulse_end", rsp_err, 1'b0);
        r.core_id = 4'd7;
        mem_rsp = r;
        tick();
        check("err_range", rsp_err, 1'b1);
        check("err_range_no_rsp", any_rsp(), 1'b0);

        // Backpressure on a streaming core
        do_reset();
        sb_en        = 1'b1;
        remaining[0] = 20;
        refresh_drive();
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c >= 2) check($sformatf("bp_stable_%0d", c), mem_req, make_req(0, 0));
        end
        check("bp_accepts", seq[0], 5);
        check("bp_rdy_low", core_req_rdy[0], 1'b0);
        mem_req_rdy = 1'b1;
        auto_rsp    = 1'b1;
        for (int c = 0; c < 100 && hs_cnt[0] < 20; c++) tick();
        check("bp_all_issued", hs_cnt[0], 20);
        check("bp_sb_empty", exp_q.size(), 0);

        // Credit limit
        do_reset();
        mem_req_rdy  = 1'b1;
        remaining[1] = 12;
        refresh_drive();
        repeat (30) tick();
        check("cred_core1_limit", hs_cnt[1], 8);
        remaining[0] = 3;
        remaining[3] = 2;
        refresh_drive();
        repeat (20) tick();
        check("cred_core0_runs", hs_cnt[0], 3);
        check("cred_core3_runs", hs_cnt[3], 2);
        check("cred_core1_held", hs_cnt[1], 8);
        r = make_req(1, 0);
        mem_rsp = r;
        tick();
        check("cred_rsp1", core_rsp[1], r);
        check("cred_rsp_no_err", rsp_err, 1'b0);
        repeat (20) tick();
        check("cred_one_more", hs_cnt[1], 9);
        r.core_id = 4'd7;
        mem_rsp = r;
        tick();
        check("cred_bad_err", rsp_err, 1'b1);
        repeat (10) tick();
        check("cred_unchanged", hs_cnt[1], 9);

        // Reset mid-burst
        do_reset();
        mem_req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) remaining[i] = 100;
        refresh_drive();
        repeat (6) tick();
        check("mid_busy", mem_req.vld, 1'b1);
        rst_n = 1'b0;
        #2;
        check("mid_mem_req", mem_req, '0);
        check("mid_rdy", core_req_rdy, 4'hF);
        check("mid_state", dbg_state, 1'b0);
        do_reset();
        mem_rsp = make_req(0, 0);
        tick();
        check("mid_stale_rsp_err", rsp_err, 1'b1);
        check("mid_stale_no_rsp", any_rsp(), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_interconnect_wrr.md
# mem_interconnect_wrr

Parametrised N-core-to-one-memory interconnect and the successor to the fixed 4-core interconnect. It buffers each core's requests in a per-core FIFO and arbitrates between cores with a weighted round-robin arbiter that holds a grant for a programmable burst of requests. It issues to memory over a valid/ready handshake and limits outstanding requests per core with a credit counter. Memory responses are routed back to the owning core by `core_id`. It sits between the core cluster and the memory controller.

## Interface
- `NUM_CORES`, 4: number of core ports (2..16).
- `FIFO_DEPTH`, 4: entries per core request FIFO (power of 2, ≥2).
- `MAX_OUTSTANDING`, 8: maximum issued-but-unanswered requests per core.
- `WEIGHT_W`, 4: width of each per-core weight.
- `clk`  in  1  clock.
- `reset`  in  1  reset. One clock; reset is asynchronous and active-low.
- `core_req[NUM_CORES]`  in  request_t  core requests; `.vld` qualifies.
- `core_req_rdy`  out  NUM_CORES  per-core accept. A request transfers when `.vld & rdy`.
- `core_rsp[NUM_CORES]`  out  request_t  routed responses, registered, one-cycle `.vld` pulse.
- `weight_cfg[NUM_CORES]`  in  WEIGHT_W  consecutive-grant budget per core. 0 is treated as 1. Sampled only when a new grant starts.
- `mem_req`  out  request_t  memory request. `.vld` qualifies.
- `mem_req_rdy`  in  1  memory accepts `mem_req` when `mem_req.vld & mem_req_rdy`.
- `mem_rsp`  in  request_t  memory response. `.vld` qualifies; `.core_id` selects the destination.
- `rsp_err`  out  1  one-cycle pulse: response dropped (core_id ≥ NUM_CORES, or that core has zero outstanding).

## Operation
- **FIFO acceptance.** `core_req_rdy[i] = !fifo_full[i]`. A request is pushed into FIFO i unmodified.
- **Eligibility.** Core i is eligible when `fifo_nonempty[i] & (outstanding[i] < MAX_OUTSTANDING)`.
- **Arbiter states.**
  - IDLE: no grant held. With any core eligible, grant the first eligible core searching from `rr_ptr`. Load `budget = max(weight_cfg[i],1)`. Go to GRANT.
  - GRANT: each issue from the granted core decrements `budget`. The grant ends when budget reaches 0, or the core becomes ineligible at a point where an issue is possible.
  - On grant end: `rr_ptr = granted+1`, wrapping to 0 after `NUM_CORES-1`. Re-arbitrate in the same cycle, so there are no bubble cycles between grants when another core is eligible. With no core eligible, return to IDLE.
- **Output register.** `mem_req` is an output register. It loads from the granted FIFO head, popping it, when the register is empty or being handshaken this cycle. `mem_req` is held stable while `.vld & !mem_req_rdy`.
- **Credits.** `outstanding[i]` increments on each `mem_req` handshake of core i. It decrements on a valid `mem_rsp` for core i. Both in the same cycle leave it unchanged. It saturates: never exceeds `MAX_OUTSTANDING` and never drops below 0.
- **Response routing.**
  - For a valid, in-range response with `outstanding > 0`: `core_rsp[core_id] <= mem_rsp`; all other `core_rsp` are 0.
  - Otherwise the response is dropped and `rsp_err` pulses.
  - With no valid response, all `core_rsp` are 0.
- **Core ID source.** The request's `core_id` is not rewritten. Cores are responsible for driving their own index.

## Timing
- **Reset values.** All `core_rsp` 0, `mem_req` 0, `core_req_rdy` all 1 (first cycle after reset release), `rsp_err` 0. FIFOs empty, counters 0, `rr_ptr` 0, arbiter in IDLE.
- **Reset mid-operation.** All queued and outstanding state is discarded immediately. Responses arriving after reset for previously issued requests are dropped with `rsp_err`.
- **Request latency.** A request accepted at edge t into an empty, idle path has `mem_req.vld` high after edge t+1 (visible cycle t+1).
- **Throughput.** One issue per cycle while `mem_req_rdy` is held high.
- **Response latency.** `mem_rsp` at edge t gives `core_rsp`/`rsp_err` after edge t, lasting exactly one cycle.
- **FIFO full.** `rdy` is low. A push and a pop in the same cycle on a full FIFO: the pop frees space next cycle only (`rdy` is derived from registered occupancy).
- **Credit limit mid-grant.** Hitting the limit ends the grant and passes it on.
- **Wrap-around.** `rr_ptr` wraps from `NUM_CORES-1` to 0.

## Test plan
- **Single-core latency.** Core 2 sends one request (access_length 5) with memory ready. `mem_req` equals it one cycle after acceptance. A response with core_id 2 gives a `core_rsp[2]` pulse one cycle later; other ports stay 0.
- **Equal-weight round robin.** All 4 cores saturated, weights all 1, memory always ready. The issue order is 0,1,2,3,0,1… with no idle cycles.
- **Weighted round robin.** Weights 3,1,2,1 with all cores saturated. The order is 0,0,0,1,2,2,3 repeating. Setting weight 0 on core 1 behaves as 1.
- **Backpressure.** `mem_req_rdy` held low for 10 cycles while core 0 streams. `mem_req` stays stable. After 1 output register + FIFO_DEPTH=4 accepts, `core_req_rdy[0]` drops. On release, all requests issue in order.
- **Credit limit.** With no responses returned, core 1 issues exactly 8 requests and then core 1 stalls while other cores continue. One response for core 1 allows exactly one more issue.
- **Response errors.** A response with core_id 7 (NUM_CORES=4), or for a core with 0 outstanding, pulses `rsp_err` once; all `core_rsp` stay 0 and counters are unchanged. Asserting reset mid-burst clears `mem_req` and the counters immediately.
